// File: rtl/step_counter.sv
// step_counter: registered WIDTH-bit up/down counter with programmable step and modulus MAX_VAL+1.
// Define STEP_COUNTER_SAT_EN to clamp at 0 / MAX_VAL instead of wrapping.
module step_counter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             En,
    input  logic             Up,
    input  logic [WIDTH-1:0] Step,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Clr_ovf,
    output logic [WIDTH-1:0] Q,
    output logic             Cout,
    output logic             Ovf,
    output logic             Tc
);

    localparam int unsigned   XW    = WIDTH + 1;
    localparam logic [XW-1:0] MAX_X = XW'(MAX_VAL);
`ifndef STEP_COUNTER_SAT_EN
    localparam logic [XW-1:0] MOD_X = XW'(MAX_VAL + 1);
`endif

    logic [WIDTH-1:0] q_q, q_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             ovf_set;
    logic [XW-1:0]    q_x, s_x, d_x, up_sum;
    logic             over;

    // Operands widened by one bit so the carry out of the add is never lost.
    always_comb begin
        q_x    = {1'b0, q_q};
        s_x    = ({1'b0, Step} > MAX_X) ? MAX_X : {1'b0, Step};
        d_x    = ({1'b0, D} > MAX_X) ? MAX_X : {1'b0, D};
        up_sum = q_x + s_x;
        over   = Up ? (up_sum > MAX_X) : (s_x > q_x);
    end

    always_comb begin
        q_d     = q_q;
        cout_d  = 1'b0;
        ovf_set = 1'b0;
        if (Load) begin
            q_d = WIDTH'(d_x);
        end else if (En) begin
            if (!over) begin
                q_d = Up ? WIDTH'(up_sum) : WIDTH'(q_x - s_x);
            end else begin
                ovf_set = 1'b1;
`ifdef STEP_COUNTER_SAT_EN
                // Carry only when the clamp actually moved Q onto the limit.
                q_d    = Up ? WIDTH'(MAX_X) : '0;
                cout_d = Up ? (q_x != MAX_X) : (q_x != '0);
`else
                q_d    = Up ? WIDTH'(up_sum - MOD_X) : WIDTH'(q_x + MOD_X - s_x);
                cout_d = 1'b1;
`endif
            end
        end
        ovf_d = ovf_set | (ovf_q & ~Clr_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign Q    = q_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;
    assign Tc   = En & (Up ? (q_q == WIDTH'(MAX_VAL)) : (q_q == '0));

endmodule

// File: tb/tb_step_counter.sv
// Self-checking bench for step_counter (WIDTH=4, MAX_VAL=9), directed scenarios plus random vs. model.
module tb_step_counter;

    localparam int unsigned W  = 4;
    localparam int          MV = 9;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0, up = 1'b0, load = 1'b0, clr = 1'b0;
    logic [W-1:0] step = '0, d = '0;
    logic [W-1:0] q;
    logic         cout, ovf, tc;

    int n_cmp = 0;
    int n_bad = 0;
    int m_q   = 0;
    bit m_cout = 1'b0;
    bit m_ovf  = 1'b0;

    step_counter #(.WIDTH(W), .MAX_VAL(MV)) dut (
        .clk(clk), .rst_n(rst_n), .En(en), .Up(up), .Step(step), .Load(load),
        .D(d), .Clr_ovf(clr), .Q(q), .Cout(cout), .Ovf(ovf), .Tc(tc)
    );

    always #5 clk = ~clk;

    task automatic set_in(input bit e, input bit u, input int st, input bit l, input int dv, input bit cl);
        en = e; up = u; step = W'(st); load = l; d = W'(dv); clr = cl;
    endtask

    // Reference: plain integer arithmetic on the counter value, applied at each rising edge.
    task automatic tick();
        int s, t;
        bit c, o;
        s = (int'(step) > MV) ? MV : int'(step);
        c = 1'b0;
        o = 1'b0;
        if (load) begin
            m_q = (int'(d) > MV) ? MV : int'(d);
        end else if (en) begin
            t = up ? m_q + s : m_q - s;
            if (t > MV || t < 0) begin
                o = 1'b1;
`ifdef STEP_COUNTER_SAT_EN
                c = up ? (m_q != MV) : (m_q != 0);
                t = up ? MV : 0;
`else
                c = 1'b1;
                t = (t + MV + 1) % (MV + 1);
`endif
            end
            m_q = t;
        end
        m_cout = c;
        m_ovf  = o | (m_ovf & !clr);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({q, cout, ovf} !== {W'(0), 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL reset_init got q=%0d c=%0b o=%0b want 0 0 0", q, cout, ovf);
        end
        rst_n = 1'b1;
        // Drive Ovf high, then park Q at 5 before pulling reset between edges.
        set_in(0, 0, 0, 1, 7, 0); tick();
        set_in(1, 1, 4, 0, 0, 0); tick();
        set_in(0, 0, 0, 1, 5, 0); tick();
        set_in(1, 1, 1, 0, 0, 0);
        n_cmp++;
        if ({q, ovf} !== {W'(5), 1'b1}) begin
            n_bad++; $display("FAIL reset_pre got q=%0d o=%0b want 5 1", q, ovf);
        end
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({q, cout, ovf} !== {W'(0), 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL reset_async got q=%0d c=%0b o=%0b want 0 0 0", q, cout, ovf);
        end
        m_q = 0; m_cout = 1'b0; m_ovf = 1'b0;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({q, cout} !== {W'(1), 1'b0}) begin
            n_bad++; $display("FAIL reset_release got q=%0d c=%0b want 1 0", q, cout);
        end
    endtask

`ifndef STEP_COUNTER_SAT_EN
    task automatic test_up_wrap();
        set_in(0, 0, 0, 1, 7, 1); tick();
        set_in(1, 1, 4, 0, 0, 0); tick();
        n_cmp++;
        if ({q, cout, ovf} !== {W'(1), 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL up_wrap got q=%0d c=%0b o=%0b want 1 1 1", q, cout, ovf);
        end
        set_in(0, 1, 4, 0, 0, 0); tick();
        n_cmp++;
        if ({q, cout, ovf} !== {W'(1), 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL up_wrap_hold got q=%0d c=%0b o=%0b want 1 0 1", q, cout, ovf);
        end
    endtask

    task automatic test_down_borrow();
        set_in(0, 0, 0, 1, 2, 0); tick();
        set_in(1, 0, 3, 0, 0, 0); tick();
        n_cmp++;
        if ({q, cout} !== {W'(9), 1'b1}) begin
            n_bad++; $display("FAIL down_borrow got q=%0d c=%0b want 9 1", q, cout);
        end
        set_in(1, 0, 12, 0, 0, 0); tick();
        n_cmp++;
        if ({q, cout} !== {W'(0), 1'b0}) begin
            n_bad++; $display("FAIL down_clamp_step got q=%0d c=%0b want 0 0", q, cout);
        end
    endtask
`else
    task automatic test_sat();
        set_in(0, 0, 0, 1, 8, 1); tick();
        set_in(1, 1, 5, 0, 0, 0); tick();
        n_cmp++;
        if ({q, cout, ovf} !== {W'(9), 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL sat_up got q=%0d c=%0b o=%0b want 9 1 1", q, cout, ovf);
        end
        set_in(0, 1, 5, 0, 0, 1); tick();
        set_in(1, 1, 5, 0, 0, 0); tick();
        n_cmp++;
        if ({q, cout, ovf} !== {W'(9), 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL sat_up_at_limit got q=%0d c=%0b o=%0b want 9 0 1", q, cout, ovf);
        end
        set_in(0, 0, 0, 1, 1, 0); tick();
        set_in(1, 0, 3, 0, 0, 0); tick();
        n_cmp++;
        if ({q, cout} !== {W'(0), 1'b1}) begin
            n_bad++; $display("FAIL sat_down got q=%0d c=%0b want 0 1", q, cout);
        end
    endtask
`endif

    task automatic test_load_priority();
        set_in(1, 1, 3, 1, 6, 0); tick();
        n_cmp++;
        if ({q, cout} !== {W'(6), 1'b0}) begin
            n_bad++; $display("FAIL load_prio got q=%0d c=%0b want 6 0", q, cout);
        end
        set_in(1, 1, 9, 1, 12, 0); tick();
        n_cmp++;
        if ({q, cout} !== {W'(9), 1'b0}) begin
            n_bad++; $display("FAIL load_clamp got q=%0d c=%0b want 9 0", q, cout);
        end
        set_in(1, 1, 1, 0, 0, 0);
        #1;
        n_cmp++;
        if (tc !== 1'b1) begin
            n_bad++; $display("FAIL tc_up got %0b want 1", tc);
        end
        set_in(1, 0, 1, 0, 0, 0);
        #1;
        n_cmp++;
        if (tc !== 1'b0) begin
            n_bad++; $display("FAIL tc_down_at_max got %0b want 0", tc);
        end
        set_in(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_sticky();
        set_in(0, 0, 0, 1, 8, 0); tick();
        set_in(1, 1, 5, 0, 0, 1); tick();
        n_cmp++;
        if ({cout, ovf} !== {1'b1, 1'b1}) begin
            n_bad++; $display("FAIL sticky_set_wins got c=%0b o=%0b want 1 1", cout, ovf);
        end
        set_in(0, 1, 5, 0, 0, 1); tick();
        n_cmp++;
        if ({cout, ovf} !== {1'b0, 1'b0}) begin
            n_bad++; $display("FAIL sticky_clear got c=%0b o=%0b want 0 0", cout, ovf);
        end
    endtask

    task automatic test_back_to_back();
        set_in(0, 0, 0, 1, 9, 1); tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, 9, 0, 0, 0); tick();
            n_cmp++;
            if ({q, cout, ovf} !== {W'(m_q), m_cout, m_ovf}) begin
                n_bad++;
                $display("FAIL b2b_%0d got q=%0d c=%0b o=%0b want q=%0d c=%0b o=%0b",
                         i, q, cout, ovf, m_q, m_cout, m_ovf);
            end
        end
    endtask

    task automatic test_random();
        bit exp_tc;
        for (int i = 0; i < 300; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                   1'($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)), 1'($urandom_range(0, 4) == 0));
            #1;
            exp_tc = en && (up ? (m_q == MV) : (m_q == 0));
            n_cmp++;
            if (tc !== exp_tc) begin
                n_bad++; $display("FAIL rand_tc_%0d got %0b want %0b", i, tc, exp_tc);
            end
            tick();
            n_cmp++;
            if ({q, cout, ovf} !== {W'(m_q), m_cout, m_ovf}) begin
                n_bad++;
                $display("FAIL rand_%0d got q=%0d c=%0b o=%0b want q=%0d c=%0b o=%0b",
                         i, q, cout, ovf, m_q, m_cout, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
`ifndef STEP_COUNTER_SAT_EN
        test_up_wrap();
        test_down_borrow();
`else
        test_sat();
`endif
        test_load_priority();
        test_sticky();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
